// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, state encoding, strobe constants and legality helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, WB, FAULT} state_e;
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    return st ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobe generation and load byte/half extraction with extension
// st_f3_i/st_off_i/st_data_i -> st_wdata_o/st_wstrb_o; ld_f3_i/ld_off_i/ld_rdata_i -> ld_data_o
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v = 8'(ld_rdata_i >> {ld_off_i, 3'b000});
    half_v = 16'(ld_rdata_i >> {ld_off_i[1], 4'b0000});
    st_wdata_o = st_f3_i[1:0] == 2'b00 ? {4{st_data_i[7:0]}}
               : st_f3_i[1:0] == 2'b01 ? {2{st_data_i[15:0]}} : st_data_i;
    st_wstrb_o = st_f3_i[1:0] == 2'b00 ? STRB_B << st_off_i
               : st_f3_i[1:0] == 2'b01 ? STRB_H << st_off_i : STRB_W;
    ld_data_o = ld_f3_i == F3_B  ? {{24{byte_v[7]}}, byte_v}
              : ld_f3_i == F3_BU ? {24'd0, byte_v}
              : ld_f3_i == F3_H  ? {{16{half_v[15]}}, half_v}
              : ld_f3_i == F3_HU ? {16'd0, half_v} : ld_rdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running one load/store per accept on a valid/ack data bus
// in: clk, reset, start, is_store, funct3, base, imm, store_data, rd_in, mem_ack, mem_rdata
// out: busy, mem_req/we/addr/wdata/wstrb, wb_load/rd/data, store_done, misalign, illegal
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_load,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            store_done,
  output logic            misalign,
  output logic            illegal
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] ea, st_wdata, ld_data, addr_q, wdata_q, wb_data_q;
  logic [3:0]      st_wstrb, wstrb_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q, wb_rd_q;
  logic            we_q, wb_load_q, store_done_q, misalign_q, illegal_q;
  logic            ill, mis, accept, done;
  assign ea     = base + imm;
  assign ill    = !f3_legal(is_store, funct3);
  assign mis    = f3_misaligned(funct3, ea[1:0]);
  assign busy   = state_q == REQ || state_q == FAULT;
  assign accept = start && !busy;
  assign done   = state_q == REQ && mem_ack;
  lsu_align u_align (
    .st_f3_i   (funct3),
    .st_off_i  (ea[1:0]),
    .st_data_i (store_data),
    .st_wdata_o(st_wdata),
    .st_wstrb_o(st_wstrb),
    .ld_f3_i   (f3_q),
    .ld_off_i  (off_q),
    .ld_rdata_i(mem_rdata),
    .ld_data_o (ld_data)
  );
  // WB behaves like IDLE for acceptance so a new op can issue during the writeback pulse.
  always_comb begin
    state_d = state_q == REQ   ? (mem_ack ? (we_q ? IDLE : WB) : REQ)
            : state_q == FAULT ? IDLE
            : accept           ? ((ill || mis) ? FAULT : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_load_q    <= 1'b0;
      store_done_q <= 1'b0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_load_q    <= done && !we_q && rd_q != 5'd0;
      store_done_q <= done && we_q;
      misalign_q   <= accept && !ill && mis;
      illegal_q    <= accept && ill;
      if (done && !we_q) begin
        wb_data_q <= ld_data;
        wb_rd_q   <= rd_q;
      end
      if (accept) begin
        addr_q  <= {ea[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
        wdata_q <= st_wdata;
        wstrb_q <= is_store ? st_wstrb : 4'd0;
        we_q    <= is_store;
        f3_q    <= funct3;
        off_q   <= ea[1:0];
        rd_q    <= rd_in;
      end
    end
  end
  assign mem_req    = state_q == REQ;
  assign mem_we     = we_q && mem_req;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign wb_load    = wb_load_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign store_done = store_done_q;
  assign misalign   = misalign_q;
  assign illegal    = illegal_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed expectations for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] base = '0, imm = '0, store_data = '0, mem_rdata = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, mem_req, mem_we, wb_load, store_done, misalign, illegal;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_rd;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .imm(imm), .store_data(store_data), .rd_in(rd_in), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_load(wb_load),
    .wb_rd(wb_rd), .wb_data(wb_data), .store_done(store_done), .misalign(misalign),
    .illegal(illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] i,
                       input logic [31:0] d, input logic [4:0] rd);
    start = 1'b1; is_store = st; funct3 = f3; base = b; imm = i; store_data = d; rd_in = rd;
    tick();
    start = 1'b0;
  endtask
  task automatic ack_with(input logic [31:0] rdv);
    mem_ack = 1'b1; mem_rdata = rdv;
    tick();
    mem_ack = 1'b0;
  endtask
  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_pulses", 32'({wb_load, store_done, misalign, illegal}), 32'd0);
    chk("rst_wb", wb_data, 32'd0);
    chk("rst_wbrd", 32'(wb_rd), 32'd0);
    // SW 0x100+4, ack k=1
    issue(1'b1, 3'b010, 32'h100, 32'd4, 32'h2267, 5'd0);
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_busy", 32'(busy), 32'd1);
    chk("sw_addr", mem_addr, 32'h104);
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'h2267);
    ack_with(32'h0);
    chk("sw_done", 32'(store_done), 32'd1);
    chk("sw_req_off", 32'(mem_req), 32'd0);
    chk("sw_busy_off", 32'(busy), 32'd0);
    chk("sw_nowb", 32'(wb_load), 32'd0);
    tick();
    chk("sw_done_pulse", 32'(store_done), 32'd0);
    // LB @0x103 then LBU back-to-back in the WB cycle
    issue(1'b0, 3'b000, 32'h103, 32'd0, 32'd0, 5'd1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_we", 32'(mem_we), 32'd0);
    ack_with(32'h80BF_00AA);
    chk("lb_wbload", 32'(wb_load), 32'd1);
    chk("lb_wbrd", 32'(wb_rd), 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_busy", 32'(busy), 32'd0);
    issue(1'b0, 3'b100, 32'h103, 32'd0, 32'd0, 5'd1);
    chk("lbu_b2b_req", 32'(mem_req), 32'd1);
    chk("lb_wbload_pulse", 32'(wb_load), 32'd0);
    ack_with(32'h80BF_00AA);
    chk("lbu_data", wb_data, 32'h0000_0080);
    chk("lbu_wbload", 32'(wb_load), 32'd1);
    tick();
    // SH @0x102
    issue(1'b1, 3'b001, 32'h102, 32'd0, 32'h0000_BFBF, 5'd0);
    chk("sh_addr", mem_addr, 32'h100);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBFBF_BFBF);
    ack_with(32'h0);
    chk("sh_done", 32'(store_done), 32'd1);
    tick();
    // LHU @0x102, LH sign, LB lane 1 positive
    issue(1'b0, 3'b101, 32'h102, 32'd0, 32'd0, 5'd2);
    ack_with(32'hBFBF_0000);
    chk("lhu_data", wb_data, 32'h0000_BFBF);
    tick();
    issue(1'b0, 3'b001, 32'h100, 32'd0, 32'd0, 5'd3);
    ack_with(32'h1234_8001);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    chk("lh_rd", 32'(wb_rd), 32'd3);
    tick();
    issue(1'b0, 3'b000, 32'h0FF, 32'd2, 32'd0, 5'd4);
    chk("lb1_addr", mem_addr, 32'h100);
    ack_with(32'h0000_7F00);
    chk("lb1_data", wb_data, 32'h0000_007F);
    tick();
    // SB with address wraparound: 0xFFFFFFFF+2 = 0x1
    issue(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h1234_56AB, 5'd0);
    chk("sb_addr", mem_addr, 32'h0);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    ack_with(32'h0);
    tick();
    // Top word address
    issue(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0000_000C, 32'd0, 5'd9);
    chk("top_addr", mem_addr, 32'hFFFF_FFFC);
    ack_with(32'h5A5A_A5A5);
    chk("top_data", wb_data, 32'h5A5A_A5A5);
    tick();
    // LW misaligned
    issue(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 5'd1);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_ill", 32'(illegal), 32'd0);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_busy", 32'(busy), 32'd1);
    tick();
    chk("mis_pulse_off", 32'(misalign), 32'd0);
    chk("mis_req2", 32'(mem_req), 32'd0);
    chk("mis_busy_off", 32'(busy), 32'd0);
    // Illegal load funct3 and illegal store funct3 at odd address (illegal wins)
    issue(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 5'd1);
    chk("ill_ld", 32'({illegal, misalign, mem_req}), 32'b100);
    tick();
    issue(1'b1, 3'b101, 32'h101, 32'd0, 32'd0, 5'd0);
    chk("ill_st_prio", 32'({illegal, misalign, mem_req}), 32'b100);
    tick();
    chk("ill_off", 32'({illegal, busy}), 32'd0);
    // Stalled ack: ack at 4th request cycle; start while busy ignored
    issue(1'b0, 3'b010, 32'h200, 32'd0, 32'd0, 5'd5);
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; is_store = 1'b1; funct3 = 3'b010; base = 32'h300; rd_in = 5'd6;
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", mem_addr, 32'h200);
      tick();
    end
    start = 1'b0;
    chk("stall_req4", 32'(mem_req), 32'd1);
    chk("stall_we4", 32'(mem_we), 32'd0);
    ack_with(32'hDEAD_BEEF);
    chk("stall_wb", 32'({wb_load, store_done}), 32'b10);
    chk("stall_data", wb_data, 32'hDEAD_BEEF);
    chk("stall_rd", 32'(wb_rd), 32'd5);
    tick();
    chk("stall_noqueue", 32'({mem_req, busy}), 32'd0);
    // rd=0 load: no writeback pulse
    issue(1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd0);
    ack_with(32'h1111_1111);
    chk("rd0_nowb", 32'(wb_load), 32'd0);
    chk("rd0_busy", 32'(busy), 32'd0);
    tick();
    // Reset during REQ, later ack ignored, then fresh LW
    issue(1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 5'd3);
    chk("rr_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_req_off", 32'({mem_req, busy, mem_we}), 32'd0);
    chk("rr_addr", mem_addr, 32'd0);
    ack_with(32'h9999_9999);
    chk("rr_ack_ign", 32'({wb_load, store_done, mem_req}), 32'd0);
    chk("rr_wbdata", wb_data, 32'd0);
    issue(1'b0, 3'b010, 32'h404, 32'd0, 32'd0, 5'd7);
    chk("rr_fresh_addr", mem_addr, 32'h404);
    ack_with(32'hCAFE_F00D);
    chk("rr_fresh_wb", 32'(wb_load), 32'd1);
    chk("rr_fresh_data", wb_data, 32'hCAFE_F00D);
    chk("rr_fresh_rd", 32'(wb_rd), 32'd7);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
